divider: RTL and testbench

Multi-cycle integer divider serving the 8086 DIV and IDIV instructions; it is the sequential counterpart to the single-cycle combinational ALU, which has no divide operation. The microcode sequencer loads dividend and divisor, pulses `start`, stalls on `busy` and consumes quotient, remainder and divide-error on `complete`. A divide error causes microcode to vector to INT 0.

---
 rtl/divider.sv | 128 ++++++++++++
 tb/tb_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle restoring divider for 8086 DIV/IDIV (8- and 16-bit forms)
module divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        complete,
  output logic        error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] DIVIDE = 3'd2;
  localparam logic [2:0] FIXUP  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]  state;
  logic        m8, msg;
  logic [31:0] dvd;
  logic [15:0] dvs;
  logic [15:0] rem, q, b;
  logic [4:0]  cnt;
  logic        qneg, rneg, ovf, err_r;

  logic        d_neg, s_neg, range_err;
  logic [31:0] a_abs;
  logic [15:0] b_abs, hi, lo, q_mag, q_fix, r_fix;
  logic [17:0] diff;

  always_comb begin
    d_neg = msg & (m8 ? dvd[15] : dvd[31]);
    s_neg = msg & (m8 ? dvs[7] : dvs[15]);
    a_abs = m8 ? {16'd0, dvd[15:0]} : dvd;
    if (d_neg) a_abs = m8 ? {16'd0, 16'(~dvd[15:0] + 16'd1)} : ~dvd + 32'd1;
    b_abs = m8 ? {8'd0, dvs[7:0]} : dvs;
    if (s_neg) b_abs = m8 ? {8'd0, 8'(~dvs[7:0] + 8'd1)} : ~dvs + 16'd1;
    hi = m8 ? {8'd0, a_abs[15:8]} : a_abs[31:16];
    // 8-bit low byte sits at the top of q so both forms shift out of q[15]
    lo = m8 ? {a_abs[7:0], 8'd0} : a_abs[15:0];
    diff = {1'b0, rem, q[15]} - {2'b00, b};
    q_mag = m8 ? {8'd0, q[7:0]} : q;
    q_fix = qneg ? ~q_mag + 16'd1 : q_mag;
    r_fix = rneg ? ~rem + 16'd1 : rem;
    if (m8) begin
      q_fix[15:8] = 8'd0;
      r_fix[15:8] = 8'd0;
    end
    // -128/-32768 are rejected as well, so one magnitude bound covers both signs
    range_err = msg & (ovf | (m8 ? (q_mag > 16'd127) : (q_mag > 16'd32767)));
  end

  assign busy     = (state == INIT) || (state == DIVIDE) || (state == FIXUP);
  assign complete = (state == DONE);
  assign error    = (state == DONE) && err_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      m8        <= 1'b0;
      msg       <= 1'b0;
      dvd       <= 32'd0;
      dvs       <= 16'd0;
      rem       <= 16'd0;
      q         <= 16'd0;
      b         <= 16'd0;
      cnt       <= 5'd0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      ovf       <= 1'b0;
      err_r     <= 1'b0;
      quotient  <= 16'd0;
      remainder <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m8    <= is_8_bit;
            msg   <= is_signed;
            dvd   <= dividend;
            dvs   <= divisor;
            state <= INIT;
          end else begin
            state <= IDLE;
          end
        end
        INIT: begin
          if (b_abs == 16'd0 || (!msg && hi >= b_abs)) begin
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            rem   <= hi;
            q     <= lo;
            b     <= b_abs;
            qneg  <= d_neg ^ s_neg;
            rneg  <= d_neg;
            // signed operands can still overflow the core; flag it for FIXUP
            ovf   <= hi >= b_abs;
            cnt   <= m8 ? 5'd8 : 5'd16;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (!diff[17]) rem <= diff[15:0];
          else           rem <= {rem[14:0], q[15]};
          q   <= {q[14:0], ~diff[17]};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= FIXUP;
        end
        FIXUP: begin
          err_r <= range_err;
          if (!range_err) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - vector table, corner sequences and randomized model check for divider
module tb_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_8_bit = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [15:0] divisor = 16'd0;
  logic [15:0] quotient, remainder;
  logic        busy, complete, error;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q = 16'd0;
  logic [15:0] exp_r = 16'd0;

  divider dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_8_bit(is_8_bit),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy),
    .complete(complete), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m8;
    bit          sg;
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] eq;
    logic [15:0] er;
    bit          ee;
    int          ecyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input bit m8, input bit sg, input logic [31:0] dd, input logic [15:0] dv);
    is_8_bit  = m8;
    is_signed = sg;
    dividend  = dd;
    divisor   = dv;
    start     = 1'b1;
  endtask

  // Entered at a negedge with start raised; leaves at the negedge of the complete cycle.
  task automatic wait_done(input bit poke, output int cyc, output bit e);
    bit ok;
    ok  = 1'b1;
    cyc = -1;
    e   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (complete) begin
        cyc = k;
        e   = error;
        if (busy) ok = 1'b0;
        break;
      end
      if (!busy || error) ok = 1'b0;
      if (poke && k == 5) begin
        start     = 1'b1;
        dividend  = $urandom;
        divisor   = $urandom;
        is_8_bit  = ~is_8_bit;
        is_signed = ~is_signed;
      end
      if (poke && k == 6) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_error_shape", ok, 1);
  endtask

  task automatic run_op(input bit m8, input bit sg, input logic [31:0] dd, input logic [15:0] dv,
                        input bit poke, output int cyc, output bit e);
    @(negedge clk);
    issue(m8, sg, dd, dv);
    wait_done(poke, cyc, e);
    @(negedge clk);
    check("complete_single_pulse", {complete, error}, 2'b00);
  endtask

  // Reference: plain integer division with truncation toward zero and 8086 range rules.
  task automatic model(input bit m8, input bit sg, input logic [31:0] dd, input logic [15:0] dv,
                       output bit e, output int cyc);
    longint d, v, qq, rr, lim, umax, mask;
    int n;
    n    = m8 ? 8 : 16;
    mask = (longint'(1) << n) - 1;
    umax = mask;
    lim  = (longint'(1) << (n - 1)) - 1;
    if (sg) begin
      d = m8 ? longint'($signed(dd[15:0])) : longint'($signed(dd));
      v = m8 ? longint'($signed(dv[7:0])) : longint'($signed(dv));
    end else begin
      d = m8 ? longint'(dd[15:0]) : longint'(dd);
      v = m8 ? longint'(dv[7:0]) : longint'(dv);
    end
    e   = 1'b0;
    cyc = n + 3;
    if (v == 0) begin
      e = 1'b1; cyc = 2; return;
    end
    qq = d / v;
    rr = d % v;
    if (!sg && qq > umax) begin
      e = 1'b1; cyc = 2; return;
    end
    if (sg && (qq > lim || qq < -lim)) begin
      e = 1'b1; return;
    end
    exp_q = 16'(qq & mask);
    exp_r = 16'(rr & mask);
  endtask

  initial begin
    vec_t vt[$];
    int cyc, ecyc;
    bit e, ee;

    vt.push_back('{0, 0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 0, 19});
    vt.push_back('{1, 0, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 0, 11});
    vt.push_back('{0, 1, 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 19});
    vt.push_back('{1, 1, 32'h0000_FF00, 16'h0002, 16'hFFFD, 16'hFFFF, 1, 11});
    vt.push_back('{0, 0, 32'h0000_0005, 16'h0000, 16'hFFFD, 16'hFFFF, 1, 2});
    vt.push_back('{1, 1, 32'h0000_0005, 16'hFF00, 16'hFFFD, 16'hFFFF, 1, 2});
    vt.push_back('{0, 0, 32'h0002_0000, 16'h0002, 16'hFFFD, 16'hFFFF, 1, 2});
    vt.push_back('{0, 1, 32'hFFFF_8000, 16'h0001, 16'hFFFD, 16'hFFFF, 1, 19});
    vt.push_back('{1, 1, 32'h0000_0064, 16'h00F9, 16'h00F2, 16'h0002, 0, 11});
    vt.push_back('{1, 1, 32'h0000_FF81, 16'h0001, 16'h0081, 16'h0000, 0, 11});
    vt.push_back('{1, 0, 32'h0000_00FF, 16'h0001, 16'h00FF, 16'h0000, 0, 11});
    vt.push_back('{0, 0, 32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 19});

    #1;
    check("reset_quotient", quotient, 16'h0000);
    check("reset_remainder", remainder, 16'h0000);
    check("reset_busy_complete_error", {busy, complete, error}, 3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      run_op(vt[i].m8, vt[i].sg, vt[i].dd, vt[i].dv, 1'b0, cyc, e);
      check($sformatf("vec%0d_cycle", i), cyc, vt[i].ecyc);
      check($sformatf("vec%0d_error", i), e, vt[i].ee);
      check($sformatf("vec%0d_quotient", i), quotient, vt[i].eq);
      check($sformatf("vec%0d_remainder", i), remainder, vt[i].er);
    end

    // Back-to-back: second start raised during the DONE cycle of the first
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h0000_0064, 16'h0007);
    wait_done(1'b0, cyc, e);
    check("b2b_first_cycle", cyc, 11);
    check("b2b_first_quotient", quotient, 16'h000E);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002);
    wait_done(1'b0, cyc, e);
    check("b2b_second_cycle", cyc, 19);
    check("b2b_second_result", {error, quotient, remainder}, {1'b0, 16'hFFFD, 16'hFFFF});

    // Asynchronous reset mid-divide
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0001_0000, 16'h0003);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_outputs", {quotient, remainder}, 32'h0);
    check("midreset_complete", complete, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, 1'b0, 32'h0000_0064, 16'h000A, 1'b0, cyc, e);
    check("post_reset_cycle", cyc, 19);
    check("post_reset_result", {error, quotient, remainder}, {1'b0, 16'h000A, 16'h0000});

    exp_q = 16'h000A;
    exp_r = 16'h0000;
    for (int n = 0; n < 150; n++) begin
      bit m8, sg, poke;
      logic [31:0] dd;
      logic [15:0] dv;
      m8   = 1'($urandom);
      sg   = 1'($urandom);
      poke = 1'($urandom);
      dd   = $urandom;
      dv   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dv = 16'd0;
      if ($urandom_range(0, 3) != 0) begin
        if (m8) dd[15:8] = 8'(dd[15:8] % (dv[7:0] == 8'd0 ? 8'd1 : dv[7:0]));
        else    dd[31:16] = 16'(dd[31:16] % (dv == 16'd0 ? 16'd1 : dv));
      end
      model(m8, sg, dd, dv, ee, ecyc);
      run_op(m8, sg, dd, dv, poke, cyc, e);
      check($sformatf("rand%0d_cycle", n), cyc, ecyc);
      check($sformatf("rand%0d_error", n), e, ee);
      check($sformatf("rand%0d_result", n), {quotient, remainder}, {exp_q, exp_r});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
